// File: rtl/store_buffer.sv
// store_buffer
// Posted-write FIFO between the core's store path and the data-memory port.
// Each cycle the core may present one store (memwrite/address/data). Accepted
// stores are queued in a DEPTH-entry ring buffer and drained in issue order to
// memory. When the buffer is full, stall is raised so the core holds the store.
//
// Optional feature: define STORE_BUF_FWD_EN to add store-to-load forwarding
// (ld_addr in, fwd_hit/fwd_data out). When undefined, those ports and the
// compare logic are absent.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   memwrite       core store request this cycle
//   address        store byte address
//   data           store data
//   stall          buffer full; core must hold the store and pc
//   mem_req_valid  head entry presented to memory
//   mem_req_addr   head entry address
//   mem_req_data   head entry data
//   mem_req_ready  memory accepts the head entry this cycle
//   empty          no entries buffered
//   count          number of occupied entries
//   misalign       sticky: a store with address[2:0] != 0 was accepted
//   ld_addr        (fwd only) load address being looked up
//   fwd_hit        (fwd only) a buffered store matches the load doubleword
//   fwd_data       (fwd only) data of the youngest matching store, else 0
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Once mem_req_valid is high, valid/addr/data hold until that transfer;
// a presented request is never retracted. All outputs decode flopped state only.

module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memwrite,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        data,
  output logic                     stall,
  output logic                     mem_req_valid,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_data,
  input  logic                     mem_req_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     misalign
`ifdef STORE_BUF_FWD_EN
  ,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              enq;
  logic              deq;

  // Status decoded from the occupancy counter only.
  assign stall         = (count == CNT_W'(DEPTH));
  assign empty         = (count == '0);
  assign mem_req_valid = !empty;
  assign mem_req_addr  = addr_mem[head];
  assign mem_req_data  = data_mem[head];

  // stall gates enq, so a full buffer never accepts even when it drains the
  // same cycle; an empty buffer has valid low, so no same-cycle forwarding.
  assign enq = memwrite && !stall;
  assign deq = mem_req_valid && mem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      misalign <= 1'b0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (enq && (address[2:0] != 3'b000)) misalign <= 1'b1;
    end
  end

  // Entry storage needs no reset: contents are only observed while occupied.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail] <= address;
      data_mem[tail] <= data;
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Walk from oldest (head) to youngest; a later match overwrites an earlier
  // one so the youngest matching store wins. Only occupied slots compare.
  logic [PTR_W-1:0] idx;
  logic             ld_lo_unused;

  assign ld_lo_unused = ^ld_addr[2:0];

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) &&
          (addr_mem[idx][ADDR_W-1:3] == ld_addr[ADDR_W-1:3])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end
`endif

endmodule
